// File: rtl/pipe_controller.sv
// Pipeline control: decodes the ID-stage instruction into a 21-bit control bundle, carries it
// through the EX/MEM/WB stage registers and generates the load-use stall.
// The M extension decode is enabled by defining PIPE_CTRL_M_EXT_EN.
module pipe_controller #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned INTERLOCK  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr,
  input  logic                  instrValid,
  input  logic                  flush,
  input  logic                  hold,
  output logic                  stallOut,
  output logic [20:0]           exCtrl,
  output logic [20:0]           memCtrlBus,
  output logic [20:0]           wbCtrl,
  output logic [REG_ADDR_W-1:0] exRd,
  output logic [REG_ADDR_W-1:0] memRd,
  output logic [REG_ADDR_W-1:0] wbRd
);

  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic       mul_en;
    logic       reg_wr;
    logic       mem_wr;
    logic [1:0] wb_sel;
    logic [2:0] branch_ctrl;
    logic [2:0] mem_op;
    logic       alu_s1;
    logic       alu_s2;
    logic       do_branch;
    logic       do_jump;
    logic [3:0] alu_op;
  } ctrl_t;

  localparam ctrl_t Bubble = '{
    valid:       1'b0,
    illegal:     1'b0,
    mul_en:      1'b0,
    reg_wr:      1'b0,
    mem_wr:      1'b0,
    wb_sel:      2'b11,
    branch_ctrl: 3'b011,
    mem_op:      3'b000,
    alu_s1:      1'b0,
    alu_s2:      1'b0,
    do_branch:   1'b0,
    do_jump:     1'b0,
    alu_op:      4'b1001
  };

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  // Register-index bits that do not exist in this configuration (none for RV32I).
  localparam logic [4:0] HiMask = 5'(~((32'd1 << REG_ADDR_W) - 32'd1));

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  ctrl_t                  dec;
  logic [REG_ADDR_W-1:0]  dec_rd;
  logic                   use_rd;
  logic                   use_rs1;
  logic                   use_rs2;
  logic                   bad;

  always_comb begin
    dec        = Bubble;
    dec.valid  = 1'b1;
    dec.alu_op = 4'b0000;
    use_rd     = 1'b0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    bad        = 1'b0;

    case (opcode)
      OpReg: begin
        use_rd      = 1'b1;
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        dec.reg_wr  = 1'b1;
        dec.wb_sel  = 2'b00;
        dec.alu_s2  = 1'b1;
        if (funct7 == 7'h00) begin
          dec.alu_op = {1'b0, funct3};
        end else if (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          dec.alu_op = {1'b1, funct3};
`ifdef PIPE_CTRL_M_EXT_EN
        end else if (funct7 == 7'h01) begin
          dec.mul_en = 1'b1;
          dec.alu_op = {1'b0, funct3};
`endif
        end else begin
          bad = 1'b1;
        end
      end
      OpImm: begin
        use_rd     = 1'b1;
        use_rs1    = 1'b1;
        dec.reg_wr = 1'b1;
        dec.wb_sel = 2'b00;
        dec.alu_op = {1'b0, funct3};
        // Only the shift encodings carry funct7; elsewhere those bits are immediate.
        if (funct3 == 3'b001 && funct7 != 7'h00) begin
          bad = 1'b1;
        end else if (funct3 == 3'b101) begin
          if (funct7 == 7'h20) begin
            dec.alu_op = 4'b1101;
          end else if (funct7 != 7'h00) begin
            bad = 1'b1;
          end
        end
      end
      OpLoad: begin
        use_rd     = 1'b1;
        use_rs1    = 1'b1;
        dec.reg_wr = 1'b1;
        dec.wb_sel = 2'b01;
        case (funct3)
          3'b000:  dec.mem_op = 3'b000;
          3'b001:  dec.mem_op = 3'b001;
          3'b010:  dec.mem_op = 3'b010;
          3'b100:  dec.mem_op = 3'b011;
          3'b101:  dec.mem_op = 3'b100;
          default: bad = 1'b1;
        endcase
      end
      OpStore: begin
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        dec.mem_wr = 1'b1;
        case (funct3)
          3'b000:  dec.mem_op = 3'b101;
          3'b001:  dec.mem_op = 3'b110;
          3'b010:  dec.mem_op = 3'b111;
          default: bad = 1'b1;
        endcase
      end
      OpBranch: begin
        use_rs1         = 1'b1;
        use_rs2         = 1'b1;
        dec.do_branch   = 1'b1;
        dec.alu_s1      = 1'b1;
        dec.branch_ctrl = funct3;
        if (funct3 == 3'b010 || funct3 == 3'b011) begin
          bad = 1'b1;
        end
      end
      OpLui: begin
        use_rd     = 1'b1;
        dec.reg_wr = 1'b1;
        dec.wb_sel = 2'b00;
      end
      OpAuipc: begin
        use_rd     = 1'b1;
        dec.reg_wr = 1'b1;
        dec.wb_sel = 2'b00;
        dec.alu_s1 = 1'b1;
      end
      OpJal: begin
        use_rd      = 1'b1;
        dec.reg_wr  = 1'b1;
        dec.wb_sel  = 2'b10;
        dec.alu_s1  = 1'b1;
        dec.do_jump = 1'b1;
      end
      OpJalr: begin
        use_rd      = 1'b1;
        use_rs1     = 1'b1;
        dec.reg_wr  = 1'b1;
        dec.wb_sel  = 2'b10;
        dec.do_jump = 1'b1;
        if (funct3 != 3'b000) begin
          bad = 1'b1;
        end
      end
      default: bad = 1'b1;
    endcase

    if ((use_rd && |(rd & HiMask)) || (use_rs1 && |(rs1 & HiMask)) ||
        (use_rs2 && |(rs2 & HiMask))) begin
      bad = 1'b1;
    end

    if (bad) begin
      dec         = Bubble;
      dec.valid   = 1'b1;
      dec.illegal = 1'b1;
    end

    dec_rd = (use_rd && !bad) ? rd[REG_ADDR_W-1:0] : '0;
  end

  ctrl_t                 ex_q, mem_q, wb_q;
  ctrl_t                 ex_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, mem_rd_q, wb_rd_q;
  logic [REG_ADDR_W-1:0] ex_rd_d;
  logic [4:0]            ex_rd_ext;
  logic                  load_use;

  assign ex_rd_ext = 5'(ex_rd_q);

  assign load_use = (INTERLOCK != 0) && instrValid && ex_q.valid && (ex_q.wb_sel == 2'b01) &&
                    (ex_rd_q != '0) &&
                    ((use_rs1 && rs1 == ex_rd_ext) || (use_rs2 && rs2 == ex_rd_ext));

  // Hold and flush both override the stall; the frontend must not freeze on a squashed slot.
  assign stallOut = load_use && !flush && !hold && !rst;

  always_comb begin
    ex_d    = dec;
    ex_rd_d = dec_rd;
    if (flush || !instrValid || load_use) begin
      ex_d    = Bubble;
      ex_rd_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q     <= Bubble;
      mem_q    <= Bubble;
      wb_q     <= Bubble;
      ex_rd_q  <= '0;
      mem_rd_q <= '0;
      wb_rd_q  <= '0;
    end else if (!hold) begin
      ex_q     <= ex_d;
      mem_q    <= ex_q;
      wb_q     <= mem_q;
      ex_rd_q  <= ex_rd_d;
      mem_rd_q <= ex_rd_q;
      wb_rd_q  <= mem_rd_q;
    end
  end

  assign exCtrl     = ex_q;
  assign memCtrlBus = mem_q;
  assign wbCtrl     = wb_q;
  assign exRd       = ex_rd_q;
  assign memRd      = mem_rd_q;
  assign wbRd       = wb_rd_q;

endmodule

// File: tb/tb_pipe_controller.sv
// Scoreboard bench for pipe_controller: directed instruction stream, expected stage contents
// queued by the driver and checked by an independent monitor on the falling edge.
module tb_pipe_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        instr_valid = 1'b0;
  logic        flush = 1'b0;
  logic        hold = 1'b0;

  logic        stall_m, stall_n, stall_w;
  logic [20:0] ex_m, mem_m, wb_m, ex_n, mem_n, wb_n, ex_w, mem_w, wb_w;
  logic [4:0]  exrd_m, memrd_m, wbrd_m, exrd_n, memrd_n, wbrd_n;
  logic [3:0]  exrd_w, memrd_w, wbrd_w;

  pipe_controller #(.REG_ADDR_W(5), .INTERLOCK(1)) u_main (
    .clk(clk), .rst(rst), .instr(instr), .instrValid(instr_valid), .flush(flush), .hold(hold),
    .stallOut(stall_m), .exCtrl(ex_m), .memCtrlBus(mem_m), .wbCtrl(wb_m),
    .exRd(exrd_m), .memRd(memrd_m), .wbRd(wbrd_m)
  );

  pipe_controller #(.REG_ADDR_W(5), .INTERLOCK(0)) u_noil (
    .clk(clk), .rst(rst), .instr(instr), .instrValid(instr_valid), .flush(flush), .hold(hold),
    .stallOut(stall_n), .exCtrl(ex_n), .memCtrlBus(mem_n), .wbCtrl(wb_n),
    .exRd(exrd_n), .memRd(memrd_n), .wbRd(wbrd_n)
  );

  pipe_controller #(.REG_ADDR_W(4), .INTERLOCK(1)) u_w4 (
    .clk(clk), .rst(rst), .instr(instr), .instrValid(instr_valid), .flush(flush), .hold(hold),
    .stallOut(stall_w), .exCtrl(ex_w), .memCtrlBus(mem_w), .wbCtrl(wb_w),
    .exRd(exrd_w), .memRd(memrd_w), .wbRd(wbrd_w)
  );

  typedef struct {
    int          step;
    logic        stall;
    logic [25:0] ex;
    logic [25:0] mem;
    logic [25:0] wb;
    bit          aux_noil;
    logic [25:0] noil_ex;
    bit          aux_w4;
    logic [24:0] w4_ex;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   step_no = 0;

  logic [25:0] m_ex, m_mem, m_wb;
  bit          aux_noil = 1'b0;
  logic [25:0] aux_noil_ex = '0;
  bit          aux_w4 = 1'b0;
  logic [24:0] aux_w4_ex = '0;

  function automatic logic [20:0] mk(input logic v, input logic il, input logic mu,
                                     input logic rw, input logic mw, input logic [1:0] wbs,
                                     input logic [2:0] br, input logic [2:0] mo,
                                     input logic s1, input logic s2, input logic db,
                                     input logic dj, input logic [3:0] op);
    return {v, il, mu, rw, mw, wbs, br, mo, s1, s2, db, dj, op};
  endfunction

  task automatic check(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s step %0d: got %h, expected %h", name, step, act, req);
    end
  endtask

  // Monitor: stallOut is checked in the cycle the inputs are presented, stage registers one
  // falling edge later (after the rising edge that consumed those inputs).
  initial begin
    exp_t cur;
    exp_t pend;
    bit   have_pend;
    have_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (have_pend) begin
        check("ex", pend.step, 32'({ex_m, exrd_m}), 32'(pend.ex));
        check("mem", pend.step, 32'({mem_m, memrd_m}), 32'(pend.mem));
        check("wb", pend.step, 32'({wb_m, wbrd_m}), 32'(pend.wb));
        if (pend.aux_noil) check("noil_ex", pend.step, 32'({ex_n, exrd_n}), 32'(pend.noil_ex));
        if (pend.aux_w4) check("w4_ex", pend.step, 32'({ex_w, exrd_w}), 32'(pend.w4_ex));
      end
      have_pend = 1'b0;
      if (sb_q.size() > 0) begin
        cur = sb_q.pop_front();
        check("stall", cur.step, 32'(stall_m), 32'(cur.stall));
        if (cur.aux_noil) check("noil_stall", cur.step, 32'(stall_n), 32'd0);
        pend      = cur;
        have_pend = 1'b1;
      end
    end
  end

  task automatic step(input logic r, input logic [31:0] ins, input logic iv, input logic fl,
                      input logic hd, input logic exp_stall, input logic [20:0] exc,
                      input logic [4:0] exr);
    exp_t e;
    @(posedge clk);
    #1;
    rst         = r;
    instr       = ins;
    instr_valid = iv;
    flush       = fl;
    hold        = hd;
    if (r) begin
      m_ex  = {mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9),
               5'd0};
      m_mem = m_ex;
      m_wb  = m_ex;
    end else if (!hd) begin
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = {exc, exr};
    end
    step_no++;
    e.step     = step_no;
    e.stall    = exp_stall;
    e.ex       = m_ex;
    e.mem      = m_mem;
    e.wb       = m_wb;
    e.aux_noil = aux_noil;
    e.noil_ex  = aux_noil_ex;
    e.aux_w4   = aux_w4;
    e.w4_ex    = aux_w4_ex;
    sb_q.push_back(e);
    aux_noil = 1'b0;
    aux_w4   = 1'b0;
  endtask

  initial begin
    logic [20:0] bub, add, sub, lw, sw, beq, jal, lui, srai, ill, mul_exp;
    logic [4:0]  mul_rd;
    bub  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9);
    ill  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9);
    add  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd3, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    sub  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd3, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd8);
    lw   = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 3'd3, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    sw   = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 3'd3, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    beq  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    jal  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    lui  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    srai = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd13);
`ifdef PIPE_CTRL_M_EXT_EN
    mul_exp = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 3'd3, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    mul_rd  = 5'd1;
`else
    mul_exp = ill;
    mul_rd  = 5'd0;
`endif

    //    rst   instr          iv    flush hold  stall expected ex
    step(1'b1, 32'h003100B3, 1'b1, 1'b0, 1'b0, 1'b0, bub, 5'd0);
    aux_w4 = 1'b1; aux_w4_ex = {add, 4'd1};
    step(1'b0, 32'h003100B3, 1'b1, 1'b0, 1'b0, 1'b0, add, 5'd1);   // add x1,x2,x3
    step(1'b0, 32'h403100B3, 1'b1, 1'b0, 1'b0, 1'b0, sub, 5'd1);   // sub x1,x2,x3
    step(1'b0, 32'h0000A283, 1'b1, 1'b0, 1'b0, 1'b0, lw, 5'd5);    // lw x5,0(x1)
    aux_noil = 1'b1; aux_noil_ex = {add, 5'd6};
    step(1'b0, 32'h00528333, 1'b1, 1'b0, 1'b0, 1'b1, bub, 5'd0);   // load-use stall
    step(1'b0, 32'h00528333, 1'b1, 1'b0, 1'b0, 1'b0, add, 5'd6);   // replayed add
    step(1'b0, 32'h0000A283, 1'b1, 1'b0, 1'b0, 1'b0, lw, 5'd5);
    step(1'b0, 32'h00528333, 1'b1, 1'b1, 1'b0, 1'b0, bub, 5'd0);   // flush beats hazard
    step(1'b0, 32'h0000A283, 1'b1, 1'b0, 1'b0, 1'b0, lw, 5'd5);
    step(1'b0, 32'h00528333, 1'b1, 1'b1, 1'b1, 1'b0, bub, 5'd0);   // hold freezes all
    step(1'b0, 32'h00528333, 1'b1, 1'b0, 1'b0, 1'b1, bub, 5'd0);
    step(1'b0, 32'h00528333, 1'b1, 1'b0, 1'b0, 1'b0, add, 5'd6);
    step(1'b0, 32'h023100B3, 1'b1, 1'b0, 1'b0, 1'b0, mul_exp, mul_rd);
    step(1'b0, 32'h0020A223, 1'b1, 1'b0, 1'b0, 1'b0, sw, 5'd0);    // sw x2,4(x1)
    step(1'b0, 32'h00208463, 1'b1, 1'b0, 1'b0, 1'b0, beq, 5'd0);   // beq x1,x2,8
    step(1'b0, 32'h000000EF, 1'b1, 1'b0, 1'b0, 1'b0, jal, 5'd1);   // jal x1,0
    step(1'b0, 32'h123453B7, 1'b1, 1'b0, 1'b0, 1'b0, lui, 5'd7);   // lui x7,0x12345
    step(1'b0, 32'h40225193, 1'b1, 1'b0, 1'b0, 1'b0, srai, 5'd3);  // srai x3,x4,2
    step(1'b0, 32'h0000007F, 1'b1, 1'b0, 1'b0, 1'b0, ill, 5'd0);   // unknown opcode
    step(1'b0, 32'h003100B3, 1'b0, 1'b0, 1'b0, 1'b0, bub, 5'd0);   // instrValid low
    aux_w4 = 1'b1; aux_w4_ex = {ill, 4'd0};
    step(1'b0, 32'h00310833, 1'b1, 1'b0, 1'b0, 1'b0, add, 5'd16);  // rd=16: illegal on RV32E
    step(1'b0, 32'h403100B3, 1'b1, 1'b0, 1'b0, 1'b0, sub, 5'd1);
    step(1'b1, 32'h003100B3, 1'b1, 1'b1, 1'b1, 1'b0, bub, 5'd0);   // reset beats hold/flush
    step(1'b0, 32'h003100B3, 1'b1, 1'b0, 1'b0, 1'b0, add, 5'd1);
    step(1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, bub, 5'd0);
    step(1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, bub, 5'd0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_controller.md
PIPE_CONTROLLER -- requirements
Module: pipe_controller

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, meaning register-index width (5 = RV32I, 4 = RV32E).
REQ-002 SHALL have parameter INTERLOCK, default 1, meaning 1 enables internal load-use stall generation, 0 disables it.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port instr  input  32  instruction in ID stage.
REQ-006 SHALL have port instrValid  input  1  instr is valid this cycle.
REQ-007 SHALL have port flush  input  1  taken branch/jump resolved in EX; squash ID.
REQ-008 SHALL have port hold  input  1  external back-pressure; freeze all stage registers.
REQ-009 SHALL have port stallOut  output  1  freeze PC and IF/ID this cycle (load-use).
REQ-010 SHALL have ports exCtrl, memCtrlBus, wbCtrl  output  21 each  control bundle of EX, MEM and WB stages.
REQ-011 SHALL have ports exRd, memRd, wbRd  output  REG_ADDR_W each  destination register per stage.

Function
REQ-012 Bundle field order, MSB to LSB, SHALL be: valid, illegal, mulEn, regWR, memWR, wbSel[1:0], branchCtrl[2:0], memOp[2:0], aluS1, aluS2, doBranch, doJump, aluOp[3:0].
REQ-013 Bubble SHALL be: valid=0, illegal=0, mulEn=0, regWR=0, memWR=0, wbSel=11, branchCtrl=011, memOp=000, aluS1=0, aluS2=0, doBranch=0, doJump=0, aluOp=1001, rd=0.
REQ-014 Decode SHALL be: R-type (0110011) regWR=1, wbSel=00, aluS2=1, aluOp={f7[5],f3} for f3 000/101, {0,f3} when f7=0 for other f3, else illegal.
REQ-015 Decode SHALL be: OP-IMM (0010011) regWR=1, wbSel=00, aluOp as R-type except aluS2=0 and f7 checked only for f3 001/101.
REQ-016 Decode SHALL be: LOAD regWR=1, wbSel=01, aluOp=0000, memOp LB000/LH001/LW010/LBU011/LHU100; STORE memWR=1, aluOp=0000, memOp SB101/SH110/SW111.
REQ-017 Decode SHALL be: BRANCH doBranch=1, aluS1=1, branchCtrl=f3; LUI regWR=1, wbSel=00; AUIPC adds aluS1=1; JAL regWR=1, aluS1=1, wbSel=10, doJump=1; JALR as JAL with aluS1=0; all aluOp=0000.
REQ-018 Unlisted opcode, bad f3/f7, or any rd/rs1/rs2 index bit at or above REG_ADDR_W SHALL give bubble fields with valid=1, illegal=1.
REQ-019 Latency: ID decode SHALL appear on exCtrl 1 cycle later, memCtrlBus 2, wbCtrl 3.
REQ-020 Load-use hazard SHALL be: INTERLOCK=1 and exCtrl.valid and exCtrl.wbSel=01 and exRd!=0 and exRd matches a used rs1 (R, I, load, store, branch, JALR) or used rs2 (R, store, branch) of a valid ID instr.
REQ-021 On hazard, stallOut SHALL be 1 combinationally and a bubble SHALL enter ID/EX next edge; EX/MEM, MEM/WB advance.
REQ-022 flush SHALL load a bubble into ID/EX and force stallOut=0 (flush beats hazard).
REQ-023 hold SHALL freeze all three stage registers and force stallOut=0; hold beats flush and hazard.
REQ-024 instrValid=0 SHALL load a bubble into ID/EX.

Reset
REQ-025 While rst=1 at an edge, all three stage registers SHALL load the bubble, regardless of hold/flush; stallOut SHALL be 0 the following cycle.
REQ-026 Reset asserted mid-stream SHALL discard all in-flight instructions; first post-reset instr reaches exCtrl one edge after rst falls.

Configuration
REQ-027 Macro PIPE_CTRL_M_EXT_EN defined: R-type with f7=0000001 SHALL decode regWR=1, wbSel=00, aluS2=1, mulEn=1, aluOp={1'b0,f3}.
REQ-028 Macro PIPE_CTRL_M_EXT_EN undefined: such instructions SHALL be illegal and mulEn SHALL be constant 0.

Verification
REQ-029 rst then 0x003100B3 (add x1,x2,x3) -> after 1 edge exCtrl valid=1, regWR=1, aluS2=1, aluOp=0000, exRd=1; 0x403100B3 -> aluOp=1000.
REQ-030 0x0000A283 (lw x5,0(x1)) then 0x00528333 (add x6,x5,x5) -> stallOut=1 one cycle, bubble in EX, add reaches EX one cycle late; INTERLOCK=0 -> no stall.
REQ-031 Hazard pair as REQ-030 with flush=1 in stall cycle -> stallOut=0, ID/EX bubble; with hold=1 -> all stages unchanged, stallOut=0.
REQ-032 0x023100B3 (mul) -> mulEn=1, illegal=0 with macro; illegal=1, regWR=0 without.
REQ-033 REG_ADDR_W=4, 0x003100B3 with rd=16 (0x00310833) -> illegal=1, regWR=0; rst during 3-deep stream -> all outputs bubble next cycle.
